// File: rtl/aes_pkg.sv
// Shared AES helpers: inverse S-box, inverse round transforms, GF(2^8) math.
// Reused by the key-expansion, encrypt and decrypt cores.
package aes_pkg;

   localparam int Nb      = 4;
   localparam int BLOCK_W = 128;

   typedef logic [0:BLOCK_W-1] block_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ROUNDS = 2'd1,
      FINAL  = 2'd2
   } inv_state_e;

   // Byte x of the inverse S-box sits at bits [8*x +: 8].
   localparam logic [0:2047] INV_SBOX = {
      128'h52096ad53036a538bf40a39e81f3d7fb,
      128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e,
      128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692,
      128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506,
      128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673,
      128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b,
      128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f,
      128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961,
      128'h172b047eba77d626e169146355210c7d
   };

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a,
                                         input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = '0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   function automatic block_t inv_sub_bytes(input block_t s);
      block_t o;
      for (int i = 0; i < 16; i++)
         o[8*i +: 8] = INV_SBOX[8*int'(s[8*i +: 8]) +: 8];
      return o;
   endfunction

   // Byte index is 4*col + row; row r rotates right by r columns.
   function automatic block_t inv_shift_rows(input block_t s);
      block_t o;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[8*(4*c+r) +: 8] = s[8*(4*((c-r+4)%4)+r) +: 8];
      return o;
   endfunction

   function automatic block_t inv_mix_columns(input block_t s);
      block_t o;
      logic [7:0] a0, a1, a2, a3;
      for (int c = 0; c < 4; c++) begin
         a0 = s[32*c      +: 8];
         a1 = s[32*c + 8  +: 8];
         a2 = s[32*c + 16 +: 8];
         a3 = s[32*c + 24 +: 8];
         o[32*c      +: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b)
                           ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
         o[32*c + 8  +: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e)
                           ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
         o[32*c + 16 +: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09)
                           ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
         o[32*c + 24 +: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d)
                           ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
      end
      return o;
   endfunction

endpackage

// File: rtl/inv_round_comb.sv
// One combinational AES inverse round; last skips InvMixColumns.
module inv_round_comb
   import aes_pkg::*;
(
   input  logic [0:127] st,
   input  logic [0:127] rk,
   input  logic         last,
   output logic [0:127] o_st
);

   logic [0:127] w_ark;

   assign w_ark = inv_sub_bytes(inv_shift_rows(st)) ^ rk;
   assign o_st  = last ? w_ark : inv_mix_columns(w_ark);

endmodule

// File: rtl/inv_cipher_core.sv
// Iterative AES decrypt core, one inverse round per clock.
// Define INV_CIPHER_KEY_LATCH_EN to capture the key schedule on accept.
module inv_cipher_core
   import aes_pkg::*;
#(
   parameter int Nk = 4
) (
   input  logic                    clks,
   input  logic                    reset,
   input  logic                    start,
   input  logic [0:127]            cipherText,
   input  logic [0:128*(Nk+7)-1]   keys,
   output logic                    ready,
   output logic                    done,
   output logic [0:127]            plainText
);

   localparam int Nr = Nk + 6;
   localparam int KW = 128 * (Nr + 1);
   localparam int RW = $clog2(Nr + 1);

   inv_state_e     r_state, w_state_n;
   logic [0:127]   r_st, w_st_n;
   logic [0:127]   r_pt, w_pt_n;
   logic [RW-1:0]  r_rnd, w_rnd_n;
   logic           r_done, w_done_n;
   logic [0:KW-1]  w_keys;
   logic [0:127]   w_rk;
   logic [0:127]   w_round;
   logic           w_accept;

   assign w_accept = (r_state == IDLE) && start;

`ifdef INV_CIPHER_KEY_LATCH_EN
   logic [0:KW-1] r_keys;

   always_ff @(posedge clks) begin
      if (reset)         r_keys <= '0;
      else if (w_accept) r_keys <= keys;
   end

   assign w_keys = r_keys;
`else
   assign w_keys = keys;
`endif

   assign w_rk = w_keys[128*int'(r_rnd) +: 128];

   inv_round_comb u_round (
      .st   (r_st),
      .rk   (w_rk),
      .last (r_state == FINAL),
      .o_st (w_round)
   );

   always_ff @(posedge clks) begin
      if (reset) begin
         r_state <= IDLE;
         r_st    <= '0;
         r_pt    <= '0;
         r_rnd   <= '0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_n;
         r_st    <= w_st_n;
         r_pt    <= w_pt_n;
         r_rnd   <= w_rnd_n;
         r_done  <= w_done_n;
      end
   end

   always_comb begin
      w_state_n = r_state;
      w_st_n    = r_st;
      w_pt_n    = r_pt;
      w_rnd_n   = r_rnd;
      w_done_n  = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (start) begin
               w_st_n    = cipherText ^ keys[128*Nr +: 128];
               w_rnd_n   = RW'(Nr - 1);
               w_state_n = ROUNDS;
            end
         end
         ROUNDS: begin
            w_st_n  = w_round;
            w_rnd_n = r_rnd - RW'(1);
            if (r_rnd == RW'(1)) w_state_n = FINAL;
         end
         FINAL: begin
            w_pt_n    = w_round;
            w_done_n  = 1'b1;
            w_rnd_n   = '0;
            w_state_n = IDLE;
         end
         default: w_state_n = IDLE;
      endcase
   end

   assign ready     = (r_state == IDLE);
   assign done      = r_done;
   assign plainText = r_pt;

endmodule
